cla_seq_subtractor16: RTL and testbench

//  Multi-cycle subtractor: DIFF = A - B, computed as A + ~B + 1, one 4-bit CLA slice per cycle (LSB slice first).

---
 rtl/cla_seq_subtractor16.sv | 182 ++++++++++++++++++
 tb/tb_cla_seq_subtractor16.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_subtractor16.sv
// cla_seq_subtractor16
//   Multi-cycle subtractor. diff = a - b is formed as a + ~b + 1, one 4-bit
//   carry-lookahead slice per clock (least significant slice first). The slice
//   carry-out is registered and fed back as the next slice's carry-in, so a
//   single 4-bit CLA is shared across all slices. Valid/ready on both sides.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands a, b are valid
//   in_ready   out  1      block can accept operands (IDLE and not in reset)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   out_valid  out  1      diff/borrow/overflow/zero are valid
//   out_ready  in   1      consumer accepts result
//   diff       out  WIDTH  a - b modulo 2^WIDTH
//   borrow     out  1      unsigned a < b (inverse of final carry)
//   overflow   out  1      signed overflow of the subtraction
//   zero       out  1      diff == 0
//
// Latency: operands taken at edge T0, out_valid rises after edge T0+NSLICE.

module cla_seq_subtractor16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] nb_reg;

    logic             accept;
    logic             last_slice;
    logic [3:0]       slice_a;
    logic [3:0]       slice_nb;
    logic [4:0]       slice_res;
    logic [WIDTH-1:0] diff_next;

    // 4-bit carry-lookahead slice; returns {cout, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[3], p ^ {c[2:0], cin}};
    endfunction

    // Signed overflow of x - y. The stored operand is ~y, so the operand sign
    // bits differ exactly when x's sign equals the inverted-y sign.
    function automatic logic sub_overflow(input logic x_msb,
                                          input logic ny_msb,
                                          input logic d_msb);
        return (x_msb == ny_msb) && (d_msb != x_msb);
    endfunction

    // ---- FSM state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept     = in_valid && in_ready;
    assign last_slice = (idx == LAST_IDX);

    // ---- slice datapath: current slice plus full-result preview ----
    always_comb begin
        slice_a   = a_reg[4*idx +: 4];
        slice_nb  = nb_reg[4*idx +: 4];
        slice_res = cla4(slice_a, slice_nb, carry);
        diff_next = diff;
        diff_next[4*idx +: 4] = slice_res[3:0];
    end

    // Operands are captured only at acceptance; they need no reset because
    // nothing reads them outside RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg  <= a;
            nb_reg <= ~b;
        end
    end

    // ---- result / carry register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx   <= '0;
                        carry <= 1'b1;   // the +1 of two's-complement negation
                        diff  <= '0;
                    end
                end
                RUN: begin
                    diff  <= diff_next;
                    carry <= slice_res[4];
                    idx   <= idx + 1'b1;
                    if (last_slice) begin
                        borrow   <= ~slice_res[4];
                        overflow <= sub_overflow(a_reg[WIDTH-1], nb_reg[WIDTH-1],
                                                 diff_next[WIDTH-1]);
                        zero     <= (diff_next == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_subtractor16.sv
module tb_cla_seq_subtractor16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;

    typedef struct packed {
        logic [15:0] diff;
        logic        borrow;
        logic        overflow;
        logic        zero;
    } result_t;

    result_t sb[$];

    int n_checks;
    int n_fail;

    cla_seq_subtractor16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic result_t model(input logic [15:0] x, input logic [15:0] y);
        result_t r;
        r.diff     = x - y;
        r.borrow   = (x < y);
        r.overflow = (x[15] != y[15]) && (r.diff[15] != x[15]);
        r.zero     = (r.diff == 16'h0000);
        return r;
    endfunction

    // Present operands in IDLE; they are taken at the next rising edge.
    task automatic send_op(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        check_val("in_ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        sb.push_back(model(x, y));
        #1;
        in_valid = 1'b0;
        a = ~x;          // later operand changes must not matter
        b = x ^ y;
    endtask

    // Wait for out_valid (bounded), check latency and result fields.
    task automatic wait_result(input string tag, input int exp_lat);
        int      cyc;
        result_t e;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val({tag, "_latency"}, cyc, exp_lat);
        if (!out_valid) begin
            check_val({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            check_val({tag, "_unexpected_output"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_diff"}, diff, e.diff);
            check_val({tag, "_borrow"}, borrow, e.borrow);
            check_val({tag, "_overflow"}, overflow, e.overflow);
            check_val({tag, "_zero"}, zero, e.zero);
            check_val({tag, "_in_ready_done"}, in_ready, 1'b0);
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, "_out_valid_drop"}, out_valid, 1'b0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y);
        send_op(x, y);
        wait_result(tag, 4);
        release_result(tag);
    endtask

    initial begin
        logic [15:0] held;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1'b0);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_diff", diff, 16'h0000);
        check_val("rst_flags", {borrow, overflow, zero}, 3'b000);
        rst = 1'b0;
        #1;
        check_val("post_rst_in_ready", in_ready, 1'b1);

        run_op("basic",       16'h1234, 16'h0234);
        run_op("full_borrow", 16'h0000, 16'h0001);
        run_op("ovf_pos",     16'h8000, 16'h0001);
        run_op("ovf_neg",     16'h7FFF, 16'hFFFF);
        run_op("equal",       16'h5A5A, 16'h5A5A);

        // Back-pressure: result held, new operands ignored while in DONE.
        send_op(16'hBEEF, 16'h1234);
        wait_result("hold", 4);
        held = diff;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 16'hFFFF;
            b = 16'h0001;
            @(posedge clk);
            #1;
            check_val("hold_out_valid", out_valid, 1'b1);
            check_val("hold_in_ready", in_ready, 1'b0);
            check_val("hold_diff", diff, held);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_result("hold");
        run_op("after_hold", 16'h0010, 16'h0001);

        // Reset two cycles into RUN aborts the operation.
        send_op(16'h4321, 16'h1111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort_in_ready_in_rst", in_ready, 1'b0);
        @(posedge clk);
        #1;
        sb.delete();
        check_val("abort_out_valid", out_valid, 1'b0);
        check_val("abort_diff", diff, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("abort_in_ready_after", in_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_val("abort_no_output", out_valid, 1'b0);
        end
        run_op("after_abort", 16'h0003, 16'h0005);

        // A few pseudo-random operand pairs.
        for (int i = 0; i < 8; i++) begin
            run_op("random", 16'($urandom), 16'($urandom));
        end

        check_val("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
